// File: rtl/dmem_responder_if.sv
// dmem_responder_if: data-memory request/response bundle between the hart and its data memory.
//   master (hart)   : drives addr, ren, wen, wdata, mask; samples ready, valid, rdata, err
//   slave  (memory) : samples the request fields; drives ready, valid, rdata, err
// addr is a word-aligned byte address. wdata is already placed in its byte lanes.
// mask bit n enables bits [8n+7:8n]. rdata and err are qualified by valid.
interface dmem_responder_if;
  logic [31:0] addr;
  logic        ren;
  logic        wen;
  logic [31:0] wdata;
  logic [3:0]  mask;
  logic        ready;
  logic        valid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output addr, ren, wen, wdata, mask,
    input  ready, valid, rdata, err
  );

  modport slave (
    input  addr, ren, wen, wdata, mask,
    output ready, valid, rdata, err
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data memory for the hart's dmem port.
// Accepts one request at a time, commits it LATENCY cycles after acceptance and returns a
// one-cycle response. Holds DEPTH_WORDS 32-bit words with byte-lane write masking.
// Ports:
//   i_clk   : clock, all state on the rising edge
//   i_rst_n : asynchronous active-low reset (RAM contents are kept)
//   dmem    : slave side of the dmem bundle (request in, registered response out)
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  dmem_responder_if.slave     dmem
);

  localparam int unsigned AddrW = $clog2(DEPTH_WORDS);
  // cnt counts down from LATENCY-1, so it needs clog2(LATENCY) bits, but at least one.
  localparam int unsigned CntW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [AddrW-1:0]  idx_q;
  logic [3:0]        mask_q;
  logic [31:0]       wdata_q;
  logic              wr_q;
  logic              req_err_q;
  logic              ready_q;
  logic              valid_q;
  logic [31:0]       rdata_q;
  logic              resp_err_q;

  logic [31:0]       mem [DEPTH_WORDS];

  logic              accept;
  logic              req_err;
  logic              commit;
  logic              do_write;
  logic [31:0]       lane_mask;
  logic [31:0]       rd_word;

  always_comb begin
    // ready_q is low in StWait, so acceptance only happens from StIdle or StResp.
    accept    = ready_q & (dmem.ren | dmem.wen);
    // Any nonzero bit above the RAM's word index is out of range; addresses never alias.
    req_err   = (dmem.ren & dmem.wen) | (dmem.addr[1:0] != 2'b00) |
                ({2'b00, dmem.addr[31:2]} >= 32'(DEPTH_WORDS));
    commit    = (state_q == StWait) && (cnt_q == '0);
    do_write  = commit & wr_q & ~req_err_q;
    lane_mask = '0;
    for (int b = 0; b < 4; b++) begin
      lane_mask[8*b +: 8] = {8{mask_q[b]}};
    end
    // Writes and errors respond with zero data; reads return only enabled lanes.
    rd_word   = (wr_q | req_err_q) ? 32'h0 : (mem[idx_q] & lane_mask);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      mask_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      req_err_q  <= 1'b0;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      rdata_q    <= '0;
      resp_err_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        StIdle, StResp: begin
          if (accept) begin
            state_q   <= StWait;
            ready_q   <= 1'b0;
            cnt_q     <= CntW'(LATENCY - 1);
            idx_q     <= dmem.addr[AddrW+1:2];
            mask_q    <= dmem.mask;
            wdata_q   <= dmem.wdata;
            wr_q      <= dmem.wen;
            req_err_q <= req_err;
          end else begin
            state_q <= StIdle;
          end
        end
        StWait: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            state_q    <= StResp;
            ready_q    <= 1'b1;
            valid_q    <= 1'b1;
            rdata_q    <= rd_word;
            resp_err_q <= req_err_q;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // RAM has no reset; a pending write is dropped because reset forces state_q out of StWait.
  always_ff @(posedge i_clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (mask_q[b]) begin
          mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign dmem.ready = ready_q;
  assign dmem.valid = valid_q;
  assign dmem.rdata = rdata_q;
  assign dmem.err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of dmem_responder against a word-array
// reference model. Two instances share the request fields: dut2 (LATENCY=2) and dut1
// (LATENCY=1); sel chooses which one receives ren/wen and whose outputs are observed.
module tb_dmem_responder;
  localparam int unsigned DW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n2, rst_n1;
  logic        sel;
  logic [31:0] addr, wdata;
  logic        ren, wen;
  logic [3:0]  mask;

  dmem_responder_if bus2();
  dmem_responder_if bus1();

  assign bus2.addr  = addr;
  assign bus2.wdata = wdata;
  assign bus2.mask  = mask;
  assign bus2.ren   = ren & ~sel;
  assign bus2.wen   = wen & ~sel;
  assign bus1.addr  = addr;
  assign bus1.wdata = wdata;
  assign bus1.mask  = mask;
  assign bus1.ren   = ren & sel;
  assign bus1.wen   = wen & sel;

  dmem_responder #(.DEPTH_WORDS(DW), .LATENCY(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n2), .dmem(bus2)
  );
  dmem_responder #(.DEPTH_WORDS(DW), .LATENCY(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n1), .dmem(bus1)
  );

  logic        ready, valid, err;
  logic [31:0] rdata;
  assign ready = sel ? bus1.ready : bus2.ready;
  assign valid = sel ? bus1.valid : bus2.valid;
  assign rdata = sel ? bus1.rdata : bus2.rdata;
  assign err   = sel ? bus1.err   : bus2.err;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned vcyc;
  logic [31:0] ref_mem [2][DW];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (sel=%0d t=%0t)", tag, got, exp, sel, $time);
    end
  endtask

  function automatic int lat_of(input logic s);
    return s ? 1 : 2;
  endfunction

  function automatic logic [31:0] lanes(input logic [3:0] m);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = {8{m[b]}};
    return r;
  endfunction

  // Reference behaviour of one accepted request against the selected instance's memory.
  task automatic model(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m,
                       output logic [31:0] exp_rd, output logic exp_err);
    int unsigned idx;
    idx     = a >> 2;
    exp_err = (r && w) || (a % 4 != 0) || (idx >= DW);
    exp_rd  = 32'h0;
    if (!exp_err) begin
      if (w) ref_mem[sel][idx] = (ref_mem[sel][idx] & ~lanes(m)) | (d & lanes(m));
      else   exp_rd = ref_mem[sel][idx] & lanes(m);
    end
  endtask

  // Present a request and return #1 after the edge that accepts it; inputs are then scrambled.
  task automatic issue(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m);
    int g = 0;
    while (!ready && g < 20) begin
      @(posedge clk); #1; g++;
    end
    if (!ready) check_eq("ready_wait", {31'b0, ready}, 32'h1);
    ren = r; wen = w; addr = a; wdata = d; mask = m;
    @(posedge clk); #1;
    ren = 1'b0; wen = 1'b0;
    addr = $urandom; wdata = $urandom; mask = 4'($urandom);
  endtask

  // Return #1 after the edge that raises valid, with the number of edges since acceptance.
  task automatic wait_resp(output logic [31:0] rd, output logic er, output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!valid && lat < 20);
    if (!valid) check_eq("resp_timeout", {31'b0, valid}, 32'h1);
    rd   = rdata;
    er   = err;
    vcyc = cyc;
  endtask

  task automatic txn(input string tag, input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] m, output logic [31:0] rd);
    logic [31:0] exp_rd;
    logic        exp_err, er;
    int          lat;
    issue(r, w, a, d, m);
    model(r, w, a, d, m, exp_rd, exp_err);
    wait_resp(rd, er, lat);
    check_eq({tag, ".rdata"}, rd, exp_rd);
    check_eq({tag, ".err"}, {31'b0, er}, {31'b0, exp_err});
    check_eq({tag, ".lat"}, 32'(lat), 32'(lat_of(sel)));
  endtask

  task automatic set_rst(input logic v);
    if (sel) rst_n1 = v;
    else     rst_n2 = v;
  endtask

  // Reset while a write of 0x12345678 to 0x20 is pending: no response and no RAM update.
  task automatic mid_reset(input string tag);
    logic [31:0] rd;
    txn({tag, ".clr"}, 1'b0, 1'b1, 32'h20, 32'h0, 4'hf, rd);
    issue(1'b0, 1'b1, 32'h20, 32'h12345678, 4'hf);
    #1 set_rst(1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_eq({tag, ".valid_in_rst"}, {31'b0, valid}, 32'h0);
    end
    @(negedge clk) set_rst(1'b1);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check_eq({tag, ".valid_after_rst"}, {31'b0, valid}, 32'h0);
    end
    txn({tag, ".rd"}, 1'b1, 1'b0, 32'h20, 32'h0, 4'hf, rd);
    check_eq({tag, ".dropped"}, rd, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd, exp_rd, a;
    logic        er, exp_err, r, w;
    int          lat;
    int unsigned v1, k;

    sel = 1'b0; ren = 1'b0; wen = 1'b0; addr = '0; wdata = '0; mask = '0;
    rst_n2 = 1'b0; rst_n1 = 1'b0;
    #12;
    for (int s = 0; s < 2; s++) begin
      sel = s[0]; #1;
      check_eq("rst.ready", {31'b0, ready}, 32'h1);
      check_eq("rst.valid", {31'b0, valid}, 32'h0);
      check_eq("rst.rdata", rdata, 32'h0);
      check_eq("rst.err", {31'b0, err}, 32'h0);
    end
    @(negedge clk); rst_n2 = 1'b1; rst_n1 = 1'b1;

    // Give every word a known value; the RAM itself is never cleared.
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int i = 0; i < int'(DW); i++) txn("fill", 1'b0, 1'b1, 32'(4 * i), $urandom, 4'hf, rd);
    end

    // Asynchronous reset asserted mid-cycle while a response is on the outputs.
    sel = 1'b0;
    txn("pre_rst", 1'b0, 1'b1, 32'h0, 32'hA5A5_0001, 4'hf, rd);
    txn("pre_rst_rd", 1'b1, 1'b0, 32'h0, 32'h0, 4'hf, rd);
    #2 rst_n2 = 1'b0;
    #1;
    check_eq("async_rst.ready", {31'b0, ready}, 32'h1);
    check_eq("async_rst.valid", {31'b0, valid}, 32'h0);
    check_eq("async_rst.rdata", rdata, 32'h0);
    check_eq("async_rst.err", {31'b0, err}, 32'h0);
    @(negedge clk) rst_n2 = 1'b1;
    txn("post_rst_rd", 1'b1, 1'b0, 32'h0, 32'h0, 4'hf, rd);
    check_eq("ram_kept", rd, 32'hA5A5_0001);

    // Byte-masked write and readback.
    txn("w_full", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hf, rd);
    @(posedge clk); #1;
    check_eq("valid_one_cycle", {31'b0, valid}, 32'h0);
    txn("w_lane2", 1'b0, 1'b1, 32'h10, 32'h00AA0000, 4'b0100, rd);
    txn("r_full", 1'b1, 1'b0, 32'h10, 32'h0, 4'hf, rd);
    check_eq("merged", rd, 32'hDEAABEEF);
    txn("r_hi", 1'b1, 1'b0, 32'h10, 32'h0, 4'b1100, rd);
    check_eq("masked_rd", rd, 32'hDEAA0000);
    txn("r_m0", 1'b1, 1'b0, 32'h10, 32'h0, 4'b0000, rd);
    check_eq("mask0_rd", rd, 32'h0);
    txn("w_m0", 1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, rd);

    // Read issued in the RESP cycle of a write to the same word.
    issue(1'b0, 1'b1, 32'h10, 32'h11223344, 4'hf);
    model(1'b0, 1'b1, 32'h10, 32'h11223344, 4'hf, exp_rd, exp_err);
    wait_resp(rd, er, lat);
    check_eq("b2b.ready_in_resp", {31'b0, ready}, 32'h1);
    v1 = vcyc;
    issue(1'b1, 1'b0, 32'h10, 32'h0, 4'hf);
    wait_resp(rd, er, lat);
    check_eq("b2b.rdata", rd, 32'h11223344);
    check_eq("b2b.spacing", vcyc - v1, 32'd3);

    // Error requests.
    txn("e_rw", 1'b1, 1'b1, 32'h10, 32'h0, 4'hf, rd);
    txn("e_rw_chk", 1'b1, 1'b0, 32'h10, 32'h0, 4'hf, rd);
    check_eq("e_rw_unchanged", rd, 32'h11223344);
    txn("e_misalign", 1'b1, 1'b0, 32'h12, 32'h0, 4'hf, rd);
    txn("e_range", 1'b0, 1'b1, 32'(4 * DW), 32'hFFFFFFFF, 4'hf, rd);
    txn("no_wrap", 1'b1, 1'b0, 32'h0, 32'h0, 4'hf, rd);
    check_eq("no_wrap_val", rd, 32'hA5A5_0001);

    mid_reset("midrst_l2");
    sel = 1'b1;
    mid_reset("midrst_l1");

    // Randomized traffic with random idle gaps (a zero gap issues in the RESP cycle).
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int n = 0; n < 150; n++) begin
        k = $urandom_range(0, 9);
        r = (k < 5) || (k == 9);
        w = (k >= 5);
        k = $urandom_range(0, 9);
        if (k == 0)      a = 32'(4 * $urandom_range(0, DW - 1) + $urandom_range(1, 3));
        else if (k == 1) a = (k[0] && $urandom_range(0, 1) == 1) ? $urandom & 32'hFFFF_FFFC
                                                                 : 32'(4 * $urandom_range(DW, DW + 64));
        else             a = 32'(4 * $urandom_range(0, DW - 1));
        txn("rand", r, w, a, $urandom, 4'($urandom), rd);
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
